// File: rtl/conv3x3_window_gen_pkg.sv
// Shared pixel/window types for the 3x3 convolution front end and core.
// The window layout is [channel][row][col]; [c][0][0] is top-left and [c][2][2] is the newest pixel.
package conv3x3_window_gen_pkg;

    localparam int DATA_WIDTH   = 8;
    localparam int NUM_CHANNELS = 3;

    typedef logic signed [DATA_WIDTH-1:0]        pixel_t;
    typedef pixel_t [NUM_CHANNELS-1:0]           chan_pixel_t;
    typedef pixel_t [NUM_CHANNELS-1:0][2:0][2:0] window_t;

endpackage

// File: rtl/conv3x3_window_gen_if.sv
// Pixel stream in / window stream out bundle between a raster source and the window generator.
interface conv3x3_window_gen_if;
    import conv3x3_window_gen_pkg::*;

    logic        sof;
    logic        pixel_valid;
    chan_pixel_t pixel_in;
    window_t     window;
    logic        valid_out;
    logic        frame_done;

    modport master (
        output sof, pixel_valid, pixel_in,
        input  window, valid_out, frame_done
    );

    modport slave (
        input  sof, pixel_valid, pixel_in,
        output window, valid_out, frame_done
    );

endinterface

// File: rtl/conv3x3_window_gen_line_buffer.sv
// Single-lane circular delay line: dout is the sample written DEPTH enables ago.
// Read-before-write on one address, so the RAM needs no clear and no read latency.
module line_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] ptr_q;

    assign dout = mem[ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (en) begin
            ptr_q <= (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr_q] <= din;
        end
    end

endmodule

// File: rtl/conv3x3_window_gen.sv
// Streaming 3x3xNUM_CHANNELS window generator ("valid" padding, no border windows).
// Two cascaded line buffers per channel supply rows r-2 and r-1 alongside the live pixel.
module conv3x3_window_gen
    import conv3x3_window_gen_pkg::*;
#(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    conv3x3_window_gen_if.slave   stream
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    logic             accept;
    logic [ROW_W-1:0] row_q, cur_row;
    logic [COL_W-1:0] col_q, cur_col;
    logic             last_col, last_row, in_window;

    // Column of three vertically adjacent pixels: [0]=row r-2, [1]=row r-1, [2]=row r.
    pixel_t col_new [NUM_CHANNELS][3];

    pixel_t [NUM_CHANNELS-1:0][2:0][1:0] hist_q;
    window_t                             window_p1;
    logic                                vld_p1;
    logic                                done_p1;

    assign accept = stream.pixel_valid;

    // sof relabels the accepted pixel as (0,0) regardless of where the old frame was.
    always_comb begin
        cur_row   = stream.sof ? '0 : row_q;
        cur_col   = stream.sof ? '0 : col_q;
        last_col  = (cur_col == COL_W'(IMG_WIDTH - 1));
        last_row  = (cur_row == ROW_W'(IMG_HEIGHT - 1));
        in_window = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
    end

    for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_ch
        logic [DATA_WIDTH-1:0] l1_q, l2_q;

        line_buffer #(.WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_l1 (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (accept),
            .din  (stream.pixel_in[ch]),
            .dout (l1_q)
        );

        line_buffer #(.WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_l2 (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (accept),
            .din  (l1_q),
            .dout (l2_q)
        );

        assign col_new[ch][0] = pixel_t'(l2_q);
        assign col_new[ch][1] = pixel_t'(l1_q);
        assign col_new[ch][2] = stream.pixel_in[ch];
    end

    // ---- stage p0 -> p1: counters, column history, registered window ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q     <= '0;
            col_q     <= '0;
            vld_p1    <= 1'b0;
            done_p1   <= 1'b0;
            hist_q    <= '0;
            window_p1 <= '0;
        end else begin
            vld_p1  <= accept && in_window;
            done_p1 <= accept && last_row && last_col;
            if (accept) begin
                col_q <= last_col ? '0 : cur_col + 1'b1;
                if (last_col) begin
                    row_q <= last_row ? '0 : cur_row + 1'b1;
                end else begin
                    row_q <= cur_row;
                end
                for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                    for (int i = 0; i < 3; i++) begin
                        hist_q[ch][i][0] <= hist_q[ch][i][1];
                        hist_q[ch][i][1] <= col_new[ch][i];
                        // Window only moves on valid positions so it holds between outputs.
                        if (in_window) begin
                            window_p1[ch][i][0] <= hist_q[ch][i][0];
                            window_p1[ch][i][1] <= hist_q[ch][i][1];
                            window_p1[ch][i][2] <= col_new[ch][i];
                        end
                    end
                end
            end
        end
    end

    assign stream.window     = window_p1;
    assign stream.valid_out  = vld_p1;
    assign stream.frame_done = done_p1;

endmodule

// File: tb/tb_conv3x3_window_gen.sv
// Self-checking bench for conv3x3_window_gen on a 4x4 image with three channels.
// A frame-buffer model predicts every output cycle; literal checks pin the model itself.
module tb_conv3x3_window_gen;
    import conv3x3_window_gen_pkg::*;

    localparam int W = 4;
    localparam int H = 4;

    logic clk;
    logic rst_n;

    conv3x3_window_gen_if ifc ();

    conv3x3_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .stream(ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int win_cnt  = 0;
    int done_cnt = 0;
    bit pattern_on = 1'b1;
    window_t win_q [$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_win(input string name, input window_t act, input window_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: keep the current frame in a 2D array, position from pixel index.
    chan_pixel_t img [H][W];
    int      n_pix;
    int      mr, mc;
    logic    exp_valid, exp_done;
    window_t exp_window;

    always @(posedge clk) begin
        if (!rst_n) begin
            n_pix      = 0;
            exp_valid  = 1'b0;
            exp_done   = 1'b0;
            exp_window = '0;
        end else begin
            exp_valid = 1'b0;
            exp_done  = 1'b0;
            if (ifc.pixel_valid) begin
                if (ifc.sof) n_pix = 0;
                mr = n_pix / W;
                mc = n_pix % W;
                img[mr][mc] = ifc.pixel_in;
                if (mr >= 2 && mc >= 2) begin
                    exp_valid = 1'b1;
                    for (int ch = 0; ch < NUM_CHANNELS; ch++)
                        for (int i = 0; i < 3; i++)
                            for (int j = 0; j < 3; j++)
                                exp_window[ch][i][j] = img[mr-2+i][mc-2+j][ch];
                end
                if (n_pix == W*H - 1) begin
                    exp_done = 1'b1;
                    n_pix    = 0;
                end else begin
                    n_pix++;
                end
            end
        end
    end

    // Core result for kernel rows {-1,0,1}, bias 0, summed over all channels.
    function automatic int core_sum(input window_t w);
        int s = 0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++)
            for (int i = 0; i < 3; i++)
                s += int'($signed(w[ch][i][2])) - int'($signed(w[ch][i][0]));
        return s;
    endfunction

    always @(posedge clk) begin
        #1;
        chk("valid_out", longint'(ifc.valid_out), longint'(exp_valid));
        chk("frame_done", longint'(ifc.frame_done), longint'(exp_done));
        chk_win("window", ifc.window, exp_window);
        if (ifc.valid_out) begin
            win_cnt++;
            win_q.push_back(ifc.window);
            if (pattern_on) chk("core_sum", core_sum(ifc.window), 18);
        end
        if (ifc.frame_done) done_cnt++;
    end

    function automatic chan_pixel_t pat(input int r, input int c, input bit neg);
        chan_pixel_t p;
        for (int ch = 0; ch < NUM_CHANNELS; ch++)
            p[ch] = pixel_t'(r*4 + c + 1 + 16*ch);
        if (neg && r == 0 && c == 0) p[0] = pixel_t'(-128);
        if (neg && r == 2 && c == 2) p[1] = pixel_t'(-1);
        return p;
    endfunction

    task automatic drive(input logic s, input logic v, input chan_pixel_t p);
        @(negedge clk);
        ifc.sof         = s;
        ifc.pixel_valid = v;
        ifc.pixel_in    = p;
    endtask

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) drive(1'b0, 1'b0, '0);
    endtask

    // Bubbles carry sof=1 and junk data to show both are ignored without pixel_valid.
    task automatic send_frame(input bit with_sof, input bit bubbles, input bit neg, input int npix);
        for (int k = 0; k < npix; k++) begin
            drive(with_sof && k == 0, 1'b1, pat(k / W, k % W, neg));
            if (bubbles) drive(1'b1, 1'b0, chan_pixel_t'($urandom));
        end
    endtask

    int w0, d0;

    initial begin
        rst_n           = 1'b0;
        ifc.sof         = 1'b0;
        ifc.pixel_valid = 1'b0;
        ifc.pixel_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid_out", longint'(ifc.valid_out), 0);
        chk("reset_frame_done", longint'(ifc.frame_done), 0);
        chk_win("reset_window", ifc.window, '0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Plain frame with sof on the first pixel.
        w0 = win_cnt; d0 = done_cnt; win_q.delete();
        send_frame(1'b1, 1'b0, 1'b0, W*H);
        idle(3);
        chk("f1_windows", win_cnt - w0, 4);
        chk("f1_done", done_cnt - d0, 1);
        if (win_q.size() == 4) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    chk("f1_first_ch0", $signed(win_q[0][0][i][j]), i*4 + j + 1);
            chk("f1_first_ch2_tl", $signed(win_q[0][2][0][0]), 33);
            chk("f1_last_ch0_br", $signed(win_q[3][0][2][2]), 16);
        end else begin
            chk("f1_queue_size", win_q.size(), 4);
        end

        // Same frame with a bubble after every pixel.
        w0 = win_cnt; d0 = done_cnt;
        send_frame(1'b1, 1'b1, 1'b0, W*H);
        idle(3);
        chk("bubble_windows", win_cnt - w0, 4);
        chk("bubble_done", done_cnt - d0, 1);

        // Back-to-back frames, second without sof.
        w0 = win_cnt; d0 = done_cnt;
        send_frame(1'b1, 1'b0, 1'b0, W*H);
        send_frame(1'b0, 1'b0, 1'b0, W*H);
        idle(3);
        chk("b2b_windows", win_cnt - w0, 8);
        chk("b2b_done", done_cnt - d0, 2);

        // sof at pixel (1,3) aborts the frame.
        w0 = win_cnt; d0 = done_cnt;
        send_frame(1'b1, 1'b0, 1'b0, 7);
        send_frame(1'b1, 1'b0, 1'b0, W*H);
        idle(3);
        chk("abort_windows", win_cnt - w0, 4);
        chk("abort_done", done_cnt - d0, 1);

        // Reset in the middle of row 2.
        send_frame(1'b1, 1'b0, 1'b0, 9);
        @(negedge clk);
        rst_n           = 1'b0;
        ifc.pixel_valid = 1'b0;
        #1;
        chk("midrst_valid_out", longint'(ifc.valid_out), 0);
        chk("midrst_frame_done", longint'(ifc.frame_done), 0);
        chk_win("midrst_window", ifc.window, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        w0 = win_cnt; d0 = done_cnt;
        send_frame(1'b0, 1'b0, 1'b0, W*H);
        idle(3);
        chk("replay_windows", win_cnt - w0, 4);
        chk("replay_done", done_cnt - d0, 1);

        // Negative pixels pass through bit-exact.
        pattern_on = 1'b0;
        w0 = win_cnt; win_q.delete();
        send_frame(1'b1, 1'b0, 1'b1, W*H);
        idle(3);
        chk("neg_windows", win_cnt - w0, 4);
        if (win_q.size() >= 1) begin
            chk("neg_m128", $signed(win_q[0][0][0][0]), -128);
            chk("neg_m1", $signed(win_q[0][1][2][2]), -1);
        end else begin
            chk("neg_queue_size", win_q.size(), 4);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
